// File: rtl/mult_seq_ctrl.sv
// Sequencer and shift-add accumulator for the 8x8 nibble-serial multiplier.
// Steps the nibble mux selects and folds each 4x4 partial product into product.
module mult_seq_ctrl #(
  parameter int NIB_W = 4
) (
  input  logic               clk,
  input  logic               reset_a,
  input  logic               start,
  input  logic [2*NIB_W-1:0] pp_in,
  output logic [1:0]         input_sel,
  output logic               busy,
  output logic               done,
  output logic [4*NIB_W-1:0] product,
  output logic [1:0]         state_out
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t             state;
  state_t             state_nx;
  logic [1:0]         count;
  logic [1:0]         count_nx;
  logic [4*NIB_W-1:0] prod_nx;
  logic [4*NIB_W-1:0] pp_ext;
  logic [4*NIB_W-1:0] pp_sh;

  assign pp_ext = {{(2*NIB_W){1'b0}}, pp_in};

  // Weight of the current partial product: lo*lo, cross terms, hi*hi
  always_comb begin
    pp_sh = pp_ext;
    unique case (count)
      2'd0:    pp_sh = pp_ext;
      2'd1,
      2'd2:    pp_sh = pp_ext << NIB_W;
      2'd3:    pp_sh = pp_ext << (2 * NIB_W);
      default: pp_sh = pp_ext;
    endcase
  end

  // Next-state, accumulation and mux select decode
  always_comb begin
    state_nx  = state;
    count_nx  = count;
    prod_nx   = product;
    input_sel = 2'b00;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_nx = CALC;
          count_nx = 2'd0;
          prod_nx  = '0;
        end
      end
      CALC: begin
        input_sel = count;
        prod_nx   = product + pp_sh;
        count_nx  = count + 2'd1;
        if (count == 2'd3) begin
          state_nx = DONE;
        end
      end
      DONE: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // State, counter, product and registered status flags
  always_ff @(posedge clk) begin
    if (reset_a) begin
      state   <= IDLE;
      count   <= 2'd0;
      product <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_nx;
      count   <= count_nx;
      product <= prod_nx;
      busy    <= (state_nx == CALC);
      done    <= (state_nx == DONE);
    end
  end

  assign state_out = state;

endmodule

// File: doc/mult_seq_ctrl.md
# mult_seq_ctrl

Sequencing and accumulation stage of the 8x8 sequential multiplier. It drives the select lines of the two 4-bit nibble muxes that feed the 4x4 multiplier. It takes back the resulting 8-bit partial product and shift-adds it into a 16-bit product register. A full 8x8 product is formed in four clock cycles after a one-cycle start request.

## Interface
Parameters:
- NIB_W, default 4: nibble width. Operands are 2·NIB_W wide, partial products 2·NIB_W wide, and the product is 4·NIB_W wide.

Ports:
- clk  in  1  sole clock; all state updates on the rising edge.
- reset_a  in  1  reset, synchronous and active-high, sampled on the rising edge of clk.
- start  in  1  request to begin a multiplication; sampled only in IDLE.
- pp_in  in  2·NIB_W  partial product (mux_out_a × mux_out_b) from the 4x4 multiplier. It is combinational from input_sel and is valid in the same cycle.
- input_sel  out  2  bit0 drives the A-operand nibble mux select, bit1 drives the B-operand nibble mux select. 0 selects the low nibble (mux_in_a) and 1 selects the high nibble (mux_in_b).
- busy  out  1  high while in CALC.
- done  out  1  one-cycle pulse when the product is final.
- product  out  4·NIB_W  accumulated product register.
- state_out  out  2  encoded state: IDLE=00, CALC=01, DONE=10; 11 is unused.

## Operation
- States:
  - IDLE: waits for start.
  - CALC: four accumulation cycles, tracked by a 2-bit count.
  - DONE: one cycle.
- IDLE → CALC when start=1:
  - product is cleared to 0.
  - count is set to 0.
- CALC, for each count value:
  - input_sel and the shift applied are:
    - count=0: input_sel=00, shift 0
    - count=1: input_sel=01, shift NIB_W
    - count=2: input_sel=10, shift NIB_W
    - count=3: input_sel=11, shift 2·NIB_W
  - On each CALC edge: product ← product + (pp_in zero-extended to 4·NIB_W) << shift, and count increments.
  - At count=3 the state moves to DONE.
- DONE → IDLE unconditionally. product holds its value until the next accepted start.
- Arithmetic is unsigned and modulo 2^(4·NIB_W). Overflow cannot occur for legal inputs (0xFF×0xFF = 0xFE01).
- input_sel is 00 in IDLE and DONE.
- start is ignored in CALC and DONE: it is not queued and not counted.
- Held-high start: the transition DONE → IDLE happens regardless of start. If start is still high in the following IDLE cycle, a new multiplication begins.

## Timing
- Reset values: state=IDLE, count=0, product=0, input_sel=00, busy=0, done=0, state_out=00.
- Reset has priority over every other event. Reset mid-CALC aborts the operation: all outputs return to their reset values on the next edge and no done pulse is produced.
- start sampled high at edge k (IDLE):
  - Edges k+1 through k+4 perform the four accumulations.
  - busy is high in the cycles after edges k through k+3.
  - done=1 and state_out=10 in the cycle after edge k+4, with product final in that same cycle.
  - State is IDLE after edge k+5.
- Latency is 4 cycles from the accepted start to done. Minimum start-to-start spacing is 6 cycles.
- input_sel changes only on clock edges and is stable for the whole cycle in which pp_in is sampled.
- done and busy are registered and are never high together.

## Test plan
- Reset: hold reset_a for 2 cycles, then release → product=0x0000, done=0, busy=0, input_sel=00, state_out=00.
- Basic multiply: bench model of the muxes and 4x4 multiplier, A=0x12, B=0x34, start pulse:
  - input_sel sequence 00, 01, 10, 11
  - pp_in sequence 0x08, 0x04, 0x06, 0x03
  - done 4 cycles after start with product=0x03A8.
- Extremes:
  - A=0xFF, B=0xFF → product=0xFE01.
  - A=0x00, B=0xB7 → product=0x0000.
  - A=0x01, B=0x01 → product=0x0001.
- Start while busy: A=0xAC, B=0x61, with start reasserted during the 2nd CALC cycle → a single done pulse, product=0x412C, no restart.
- Reset mid-operation: reset_a asserted in the 3rd CALC cycle → next cycle state_out=00 and product=0. No done pulse follows.
- Back-to-back: start held high continuously:
  - First done with 0x12×0x34=0x03A8.
  - Then one IDLE cycle, then a new operation begins.
  - Operands changed to 0x0F×0x10 give a second done with product=0x00F0.
  - product is cleared at the second start.
